umich_div_seq: RTL and testbench

- Iterative restoring integer divider, one quotient bit per clock. It is the inverse-direction companion to the library's combinational multiply operators.
- Netlist-translation flows map synthesized division/modulo operators onto this block wherever a single-cycle divider is unacceptable.
- Supports unsigned (UNS) and two's-complement (TC) operation, selected by parameter.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/umich_div_seq.sv | 116 +++++++++++
 tb/tb_umich_div_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/umich_div_seq.sv
// Iterative restoring divider: one quotient bit per clock, unsigned or two's-complement,
// valid/ready on both operand and result sides.
module umich_div_seq #(
  parameter int WIDTH = 64,
  parameter bit TC    = 1'b0
) (
  input  logic             clocked_on,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;

  // num_q shifts dividend bits out of the MSB while quotient bits enter at the LSB
  logic [WIDTH-1:0] num_q, den_q, rem_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, bz, ovf;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, q_fix, r_fix;

  assign a_neg = (TC != 1'b0) && dividend[WIDTH-1];
  assign b_neg = (TC != 1'b0) && divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  assign shifted = {rem_q, num_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, den_q};
  assign fits    = (shifted >= {1'b0, den_q});
  // whichever branch is kept is below the divisor, so it always fits in WIDTH bits
  assign rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  // with a zero divisor the magnitude path already yields R = |A|, so sign fix restores A
  assign q_fix = bz  ? {WIDTH{1'b1}} :
                 ovf ? MOST_NEG      :
                 neg_q ? -num_q : num_q;
  assign r_fix = ovf ? '0 : (neg_r ? -rem_q : rem_q);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clocked_on or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = CALC;
      CALC: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clocked_on or negedge clear_n) begin
    if (!clear_n) begin
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      bz          <= 1'b0;
      ovf         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          num_q <= a_mag;
          den_q <= b_mag;
          rem_q <= '0;
          cnt   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          bz    <= (divisor == '0);
          ovf   <= (TC != 1'b0) && (dividend == MOST_NEG) && (divisor == {WIDTH{1'b1}});
        end
        CALC: begin
          num_q <= {num_q[WIDTH-2:0], fits};
          rem_q <= rem_nx;
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= bz;
          overflow    <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_umich_div_seq.sv
// Scoreboard bench for umich_div_seq: six width/signedness instances, each with its own
// stimulus and monitor, checked against a plain-arithmetic reference.
module tb_umich_div_seq;

  localparam int NCFG = 6;

  typedef struct {
    logic [63:0] q, r;
    logic        dz, ov;
    int          acc;
  } exp_t;

  typedef struct {
    bit          tc;
    logic [63:0] a, b, q, r;
    logic        dz, ov;
  } dv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cfg%0d: got %h want %h (cycle %0d)", nm, k, act, want, cyc);
    end
  endtask

  task automatic timeout(input string nm, input int k);
    n_cmp++;
    n_fail++;
    $display("FAIL %s cfg%0d: timed out at cycle %0d", nm, k, cyc);
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // truncating division; special cases decided before any signed / or % runs
  function automatic void ref_div(input int w, input bit tc, input logic [63:0] ai, input logic [63:0] bi,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output logic ov);
    logic [63:0] m, a, b, ta, tb;
    longint sa, sb;
    m  = wmask(w);
    a  = ai & m;
    b  = bi & m;
    ta = a << (64 - w);
    tb = b << (64 - w);
    sa = $signed(ta) >>> (64 - w);
    sb = $signed(tb) >>> (64 - w);
    dz = (b == 64'd0);
    ov = tc && (a == (64'd1 << (w - 1))) && (b == m);
    if (dz)      begin q = m; r = a; end
    else if (ov) begin q = a; r = 64'd0; end
    else if (tc) begin q = 64'(sa / sb) & m; r = 64'(sa % sb) & m; end
    else         begin q = a / b; r = a % b; end
  endfunction

  function automatic dv_t dir_vec(input int i);
    dv_t d;
    case (i)
      0:       d = '{1'b0, 64'h64, 64'h0A, 64'h0A, 64'h00, 1'b0, 1'b0};
      1:       d = '{1'b0, 64'hC8, 64'h07, 64'h1C, 64'h04, 1'b0, 1'b0};
      2:       d = '{1'b0, 64'h35, 64'h00, 64'hFF, 64'h35, 1'b1, 1'b0};
      3:       d = '{1'b1, 64'hF9, 64'h02, 64'hFD, 64'hFF, 1'b0, 1'b0};
      4:       d = '{1'b1, 64'h07, 64'hFE, 64'hFD, 64'h01, 1'b0, 1'b0};
      5:       d = '{1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 1'b0, 1'b1};
      default: d = '{1'b1, 64'h64, 64'h0A, 64'h0A, 64'h00, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

  // operand mix biased toward the corners: B=0, B=+-1, A=0, A=B, small |A|, most-negative
  function automatic void rnd_pair(input int w, output logic [63:0] a, output logic [63:0] b);
    logic [63:0] m;
    m = wmask(w);
    a = {$urandom, $urandom} & m;
    b = ({$urandom, $urandom} & m) >> $urandom_range(0, w - 1);
    case ($urandom_range(0, 9))
      0: b = 64'd0;
      1: b = 64'd1;
      2: b = m;
      3: a = 64'd0;
      4: a = b;
      5: begin a = 64'd1 << (w - 1); if ($urandom_range(0, 1) == 1) b = m; end
      6: begin a = 64'($urandom_range(0, 3)); b = b | 64'h10; end
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) b = b & m;
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g
    localparam int W = (k < 2) ? 8 : (k < 4) ? 16 : 64;
    localparam bit T = ((k % 2) == 1);
    localparam int NRND = (W == 64) ? 600 : 2000;

    logic         clr_n, iv, ordy, ir, ovl, dz, ovf;
    logic [W-1:0] a, b, q, r;
    exp_t         sb[$];

    umich_div_seq #(.WIDTH(W), .TC(T)) dut (
      .clocked_on (clk),
      .clear_n    (clr_n),
      .in_valid   (iv),
      .in_ready   (ir),
      .dividend   (a),
      .divisor    (b),
      .out_valid  (ovl),
      .out_ready  (ordy),
      .quotient   (q),
      .remainder  (r),
      .div_by_zero(dz),
      .overflow   (ovf)
    );

    // called at a falling edge; returns at a falling edge while the unit is in CALC
    task automatic issue(input logic [63:0] av, input logic [63:0] bv, input bit push, input exp_t e);
      logic [63:0] t;
      int          nj;
      bit          to;
      iv = 1'b1;
      a  = av[W-1:0];
      b  = bv[W-1:0];
      to = 1'b0;
      for (int i = 0; !ir && !to; i++) begin
        if (i > 400) begin timeout("accept", k); to = 1'b1; end
        else @(negedge clk);
      end
      e.acc = cyc + 1;
      if (push && !to) sb.push_back(e);
      @(negedge clk);
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        t = {$urandom, $urandom};
        a = t[W-1:0];
        b = t[63:64-W];
        chk("busy_in_ready", k, 64'(ir), 64'd0);
        @(negedge clk);
      end
      iv = 1'b0;
    endtask

    initial begin
      exp_t        e;
      dv_t         d;
      logic [63:0] av, bv;
      clr_n = 1'b0;
      iv    = 1'b0;
      a     = '0;
      b     = '0;
      e     = '{64'd0, 64'd0, 1'b0, 1'b0, 0};
      repeat (2) @(negedge clk);
      chk("rst_in_ready", k, 64'(ir), 64'd1);
      chk("rst_out_valid", k, 64'(ovl), 64'd0);
      chk("rst_quotient", k, 64'(q), 64'd0);
      chk("rst_remainder", k, 64'(r), 64'd0);
      chk("rst_flags", k, {62'd0, dz, ovf}, 64'd0);
      clr_n = 1'b1;
      if (W == 8) begin
        // abandon a division part-way through CALC; it must leave no output behind
        issue(64'hFF, 64'h03, 1'b0, e);
        while (dut.state != dut.CALC || dut.cnt != 3'd4) @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("abort_out_valid", k, 64'(ovl), 64'd0);
        chk("abort_in_ready", k, 64'(ir), 64'd1);
        chk("abort_quotient", k, 64'(q), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
          d = dir_vec(i);
          if (d.tc == T) begin
            e.q  = d.q;
            e.r  = d.r;
            e.dz = d.dz;
            e.ov = d.ov;
            issue(d.a, d.b, 1'b1, e);
          end
        end
      end
      for (int i = 0; i < NRND; i++) begin
        rnd_pair(W, av, bv);
        ref_div(W, T, av, bv, e.q, e.r, e.dz, e.ov);
        issue(av, bv, 1'b1, e);
      end
      for (int i = 0; sb.size() != 0 || !ir; i++) begin
        if (i > 2000) begin timeout("drain", k); break; end
        @(negedge clk);
      end
      n_done++;
    end

    initial begin
      exp_t        e;
      logic [63:0] sq, sr;
      logic        sdz, sov;
      bit          seen, cons, first;
      int          hold;
      ordy  = 1'b0;
      seen  = 1'b0;
      cons  = 1'b0;
      first = 1'b1;
      hold  = 0;
      sq = 64'd0; sr = 64'd0; sdz = 1'b0; sov = 1'b0;
      forever begin
        @(negedge clk);
        if (!clr_n) begin
          seen = 1'b0;
          cons = 1'b0;
        end else begin
          if (cons) begin
            chk("post_in_ready", k, 64'(ir), 64'd1);
            chk("post_out_valid", k, 64'(ovl), 64'd0);
            chk("post_q_kept", k, 64'(q), sq);
            cons = 1'b0;
          end
          if (ovl) begin
            if (!seen) begin
              if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result cfg%0d: got q=%h with no request outstanding", k, q);
              end else begin
                e = sb.pop_front();
                chk("quotient", k, 64'(q), e.q);
                chk("remainder", k, 64'(r), e.r);
                chk("div_by_zero", k, 64'(dz), 64'(e.dz));
                chk("overflow", k, 64'(ovf), 64'(e.ov));
                // accept edge plus W+1 further edges: W+2 edges counting the accept
                chk("latency", k, 64'(cyc - e.acc), 64'(W + 1));
              end
              seen = 1'b1;
              sq = 64'(q); sr = 64'(r); sdz = dz; sov = ovf;
              hold  = first ? 5 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
              first = 1'b0;
            end else begin
              chk("hold_q", k, 64'(q), sq);
              chk("hold_r", k, 64'(r), sr);
              chk("hold_flags", k, {62'd0, dz, ovf}, {62'd0, sdz, sov});
            end
            chk("done_in_ready", k, 64'(ir), 64'd0);
            if (hold > 0) begin
              ordy = 1'b0;
              hold--;
            end else begin
              ordy = 1'b1;
              cons = 1'b1;
            end
          end else begin
            seen = 1'b0;
            ordy = ($urandom_range(0, 1) == 1);
          end
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 90000 && n_done < NCFG; t++) @(negedge clk);
    if (n_done < NCFG) timeout("run", n_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
